// File: rtl/mips_cpu_muldiv_unit_if.sv
// Execute-stage handshake between the controller/datapath and the multiply/divide unit.
interface mips_cpu_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic [4:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] result;

    modport master (
        output valid, alucontrol, srca, srcb,
        input  busy, done, hi, lo, result
    );

    modport slave (
        input  valid, alucontrol, srca, srcb,
        output busy, done, hi, lo, result
    );
endinterface

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: shift-add multiply, restoring divide,
// STEP bits retired per RUN cycle, sign fix-up and HI/LO commit in a final FIX cycle.
module mips_cpu_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input logic                   clk,
    input logic                   reset_n,
    mips_cpu_muldiv_unit_if.slave bus
);

    localparam int unsigned NITER = WIDTH / STEP;
    localparam int unsigned CNTW  = $clog2(NITER + 1);

    localparam logic [4:0] OpMultu = 5'b00111;
    localparam logic [4:0] OpMult  = 5'b01000;
    localparam logic [4:0] OpDiv   = 5'b01111;
    localparam logic [4:0] OpDivu  = 5'b10000;
    localparam logic [4:0] OpMthi  = 5'b10001;
    localparam logic [4:0] OpMtlo  = 5'b10010;
    localparam logic [4:0] OpMfhi  = 5'b11010;
    localparam logic [4:0] OpMflo  = 5'b11011;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  low_q, low_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start;
    logic              signed_op;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  amag, bmag;

    logic [WIDTH-1:0]   acc_step, low_step;
    logic [WIDTH:0]     rem, sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd;

    assign start     = bus.valid && (bus.alucontrol == OpMultu || bus.alucontrol == OpMult ||
                                     bus.alucontrol == OpDiv   || bus.alucontrol == OpDivu);
    assign signed_op = (bus.alucontrol == OpMult) || (bus.alucontrol == OpDiv);
    assign a_neg     = signed_op && bus.srca[WIDTH-1];
    assign b_neg     = signed_op && bus.srcb[WIDTH-1];
    assign amag      = a_neg ? -bus.srca : bus.srca;
    assign bmag      = b_neg ? -bus.srcb : bus.srcb;

    // STEP iterations per cycle. Multiply: {acc,low} is the product/multiplier shift pair.
    // Divide: acc holds the partial remainder, low shifts dividend out and quotient in.
    always_comb begin
        acc_step = acc_q;
        low_step = low_q;
        rem      = '0;
        sum      = '0;
        for (int i = 0; i < STEP; i++) begin
            if (is_div_q) begin
                rem      = {acc_step, low_step[WIDTH-1]};
                low_step = {low_step[WIDTH-2:0], 1'b0};
                if (rem >= {1'b0, opb_q}) begin
                    rem         = rem - {1'b0, opb_q};
                    low_step[0] = 1'b1;
                end
                acc_step = rem[WIDTH-1:0];
            end else begin
                sum      = {1'b0, acc_step} + (low_step[0] ? {1'b0, opb_q} : '0);
                low_step = {sum[0], low_step[WIDTH-1:1]};
                acc_step = sum[WIDTH:1];
            end
        end
    end

    // Sign correction; a zero divisor yields all-ones quotient and the raw dividend as remainder.
    always_comb begin
        prod = {acc_q, low_q};
        if (neg_q) prod = -prod;
        quo = low_q;
        if (dz_q)       quo = '1;
        else if (neg_q) quo = -low_q;
        rmd = rem_neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    cnt_d     = CNTW'(NITER);
                    is_div_d  = (bus.alucontrol == OpDiv) || (bus.alucontrol == OpDivu);
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dz_d      = (bus.srcb == '0);
                    acc_d     = '0;
                    low_d     = amag;
                    opb_d     = bmag;
                end else if (bus.valid && bus.alucontrol == OpMthi) begin
                    hi_d = bus.srca;
                end else if (bus.valid && bus.alucontrol == OpMtlo) begin
                    lo_d = bus.srca;
                end
            end
            StRun: begin
                acc_d = acc_step;
                low_d = low_step;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rmd;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            low_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        bus.result = '0;
        if (bus.alucontrol == OpMfhi)      bus.result = hi_q;
        else if (bus.alucontrol == OpMflo) bus.result = lo_q;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Directed bench: STEP=1 and STEP=4 instances of the multiply/divide unit, hand-computed results.
module tb_mips_cpu_muldiv_unit;

    localparam logic [4:0] MULTU = 5'b00111;
    localparam logic [4:0] MULT  = 5'b01000;
    localparam logic [4:0] DIV   = 5'b01111;
    localparam logic [4:0] DIVU  = 5'b10000;
    localparam logic [4:0] MTHI  = 5'b10001;
    localparam logic [4:0] MTLO  = 5'b10010;
    localparam logic [4:0] MFHI  = 5'b11010;
    localparam logic [4:0] MFLO  = 5'b11011;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    mips_cpu_muldiv_unit_if #(.WIDTH(32)) bus1 ();
    mips_cpu_muldiv_unit_if #(.WIDTH(32)) bus4 ();

    mips_cpu_muldiv_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    mips_cpu_muldiv_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 1) begin
            bus1.valid = v; bus1.alucontrol = op; bus1.srca = a; bus1.srcb = b;
        end else begin
            bus4.valid = v; bus4.alucontrol = op; bus4.srca = a; bus4.srcb = b;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 1) ? bus1.busy : bus4.busy;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 1) ? bus1.done : bus4.done;
    endfunction
    function automatic logic [31:0] get_hi(input int w);
        return (w == 1) ? bus1.hi : bus4.hi;
    endfunction
    function automatic logic [31:0] get_lo(input int w);
        return (w == 1) ? bus1.lo : bus4.lo;
    endfunction
    function automatic logic [31:0] get_result(input int w);
        return (w == 1) ? bus1.result : bus4.result;
    endfunction

    // Counts negedges with busy high; bounded so a stuck DUT shows up as a wrong count.
    task automatic wait_done(input int w, output int cycles);
        cycles = 0;
        while (get_busy(w) && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input int w, input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        int cyc;
        drive(w, 1'b1, op, a, b);
        @(negedge clk);
        drive(w, 1'b0, 5'd0, 32'd0, 32'd0);
        wait_done(w, cyc);
        check_eq({tag, " busy cycles"}, 64'(cyc), 64'(ecyc));
        check_eq({tag, " done"}, 64'(get_done(w)), 64'd1);
        check_eq({tag, " hi"}, 64'(get_hi(w)), 64'(ehi));
        check_eq({tag, " lo"}, 64'(get_lo(w)), 64'(elo));
    endtask

    task automatic check_reads(input int w, input string tag,
                               input logic [31:0] ehi, input logic [31:0] elo);
        drive(w, 1'b1, MFLO, 32'd0, 32'd0);
        #1 check_eq({tag, " mflo result"}, 64'(get_result(w)), 64'(elo));
        drive(w, 1'b1, MFHI, 32'd0, 32'd0);
        #1 check_eq({tag, " mfhi result"}, 64'(get_result(w)), 64'(ehi));
        drive(w, 1'b0, 5'd0, 32'd0, 32'd0);
        #1 check_eq({tag, " noop result"}, 64'(get_result(w)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int done_seen;
        int busy_seen;
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset_n  = 1'b0;
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        drive(4, 1'b0, 5'd0, 32'd0, 32'd0);
        #12;
        check_eq("reset busy", 64'(bus1.busy), 64'd0);
        check_eq("reset done", 64'(bus1.done), 64'd0);
        check_eq("reset hi", 64'(bus1.hi), 64'd0);
        check_eq("reset lo", 64'(bus1.lo), 64'd0);
        check_eq("reset busy step4", 64'(bus4.busy), 64'd0);
        #5 reset_n = 1'b1;
        @(negedge clk);

        run_op(1, "multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        @(negedge clk);
        check_eq("done single pulse", 64'(bus1.done), 64'd0);
        check_eq("idle after done", 64'(bus1.busy), 64'd0);

        run_op(1, "mult -2x3", MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 33);
        check_reads(1, "mult -2x3", 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op(1, "div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        check_reads(1, "div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(1, "divu by zero", DIVU, 32'h1234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 33);
        run_op(1, "div overflow", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        run_op(1, "div minneg by zero", DIV, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF, 33);
        run_op(1, "div neg by zero", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 33);

        // MTHI and a second MULT arrive while busy and must both be dropped.
        drive(1, 1'b1, MULTU, 32'd3, 32'd5);
        @(negedge clk);
        drive(1, 1'b1, MTHI, 32'hA5A5A5A5, 32'd0);
        @(negedge clk);
        drive(1, 1'b1, MULT, 32'd7, 32'd7);
        @(negedge clk);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        wait_done(1, cyc);
        check_eq("busy-ignore cycles", 64'(cyc + 2), 64'd33);
        check_eq("busy-ignore hi", 64'(bus1.hi), 64'd0);
        check_eq("busy-ignore lo", 64'(bus1.lo), 64'h0000000F);
        drive(1, 1'b1, MTLO, 32'h5A, 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        check_eq("mtlo lo", 64'(bus1.lo), 64'h5A);
        check_eq("mtlo hi kept", 64'(bus1.hi), 64'd0);
        check_eq("mtlo no done", 64'(bus1.done), 64'd0);
        check_eq("mtlo no busy", 64'(bus1.busy), 64'd0);
        drive(1, 1'b1, MTHI, 32'h12345678, 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        check_eq("mthi hi", 64'(bus1.hi), 64'h12345678);

        // Asynchronous reset in the middle of a MULTU.
        drive(1, 1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("pre-reset busy", 64'(bus1.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async reset busy", 64'(bus1.busy), 64'd0);
        check_eq("async reset done", 64'(bus1.done), 64'd0);
        check_eq("async reset hi", 64'(bus1.hi), 64'd0);
        check_eq("async reset lo", 64'(bus1.lo), 64'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.done) done_seen++;
            if (bus1.busy) busy_seen++;
        end
        check_eq("post-reset done count", 64'(done_seen), 64'd0);
        check_eq("post-reset busy count", 64'(busy_seen), 64'd0);
        check_eq("post-reset lo", 64'(bus1.lo), 64'd0);

        // STEP=4: nine busy cycles, each start issued in the previous op's done cycle.
        run_op(4, "s4 mult max*minneg", MULT, 32'h7FFFFFFF, 32'h80000000,
               32'hC0000000, 32'h80000000, 9);
        run_op(4, "s4 divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 9);
        run_op(4, "s4 div 7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 9);
        run_op(4, "s4 multu shift", MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 9);
        run_op(4, "s4 div -8/-3", DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2, 9);
        check_reads(4, "s4 div -8/-3", 32'hFFFFFFFE, 32'd2);
        run_op(4, "s4 divu max/1", DIVU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 9);
        run_op(4, "s4 mult -1x-1", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 9);
        @(negedge clk);
        check_eq("s4 done single pulse", 64'(bus4.done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
